// File: rtl/dragonfang_pkg.sv
// Shared types for the scalar broadcast sequencer: vector config encodings and FSM states.
package dragonfang_pkg;

   typedef enum logic [1:0] {SEW_8 = 2'b00, SEW_16 = 2'b01, SEW_32 = 2'b10, SEW_64 = 2'b11} sew_t;
   typedef enum logic [1:0] {LMUL_1 = 2'b00, LMUL_2 = 2'b01, LMUL_4 = 2'b10, LMUL_8 = 2'b11} lmul_t;
   typedef enum logic {TAIL_ZERO = 1'b0, TAIL_ONES = 1'b1} tail_fill_t;
   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} broadcast_state_t;

   function automatic int unsigned sew_bits(sew_t s);
      return 32'd8 << s;
   endfunction

endpackage

// File: rtl/broadcast_beat_former.sv
// Combinational former for one beat: replicates the scalar per element and applies the
// active/tail split against vl using each element's global index within the group.
module broadcast_beat_former
   import dragonfang_pkg::*;
#(
   parameter int unsigned VLEN = 64,
   parameter int unsigned XLEN = 64,
   parameter int unsigned BIW  = 3,
   parameter int unsigned VLW  = 7
) (
   input  logic [XLEN-1:0]   scalar,
   input  sew_t              sew,
   input  logic [BIW-1:0]    beat,
   input  logic [VLW-1:0]    vl,
   input  tail_fill_t        tail_fill,
   output logic [VLEN-1:0]   vector_output,
   output logic [VLEN/8-1:0] element_enable
);

   localparam int unsigned NB = VLEN / 8;

   int unsigned epb;
   int unsigned base;
   int unsigned g;
   int unsigned bsel;

   always_comb begin
      vector_output  = '0;
      element_enable = '0;
      epb            = NB >> sew;
      base           = 32'(beat) * epb;
      g              = 0;
      bsel           = 0;
      for (int j = 0; j < NB; j++) begin
         // byte j sits in element j/bytes_per_elem, at offset j%bytes_per_elem in the scalar
         g    = base + (unsigned'(j) >> sew);
         bsel = unsigned'(j) & ((32'd1 << sew) - 32'd1);
         element_enable[j] = (g < 32'(vl));
         vector_output[8*j +: 8] = element_enable[j] ? scalar[8*bsel +: 8]
                                                     : {8{tail_fill == TAIL_ONES}};
      end
   end

endmodule

// File: rtl/scalar_broadcast_sequencer.sv
// Replicates a scalar across a vector register group, one VLEN beat per cycle, with
// valid/ready on both sides and no bubble between back-to-back groups.
module scalar_broadcast_sequencer
   import dragonfang_pkg::*;
#(
   parameter  int unsigned VLEN     = 64,
   parameter  int unsigned XLEN     = 64,
   parameter  int unsigned MAX_LMUL = 8,
   localparam int unsigned VLW      = $clog2(VLEN / 8 * MAX_LMUL) + 1,
   localparam int unsigned BIW      = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   scalar_input,
   input  logic [1:0]        sew,
   input  logic [1:0]        lmul,
   input  logic [VLW-1:0]    vl,
   input  logic              tail_fill,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VLEN-1:0]   vector_output,
   output logic [VLEN/8-1:0] element_enable,
   output logic [BIW-1:0]    beat_index,
   output logic              last_beat
);

   localparam int unsigned NB     = VLEN / 8;
   localparam logic [1:0]  MaxLog = 2'($clog2(MAX_LMUL));

   broadcast_state_t  state_q, state_d;
   logic [XLEN-1:0]   scalar_q, scalar_d;
   sew_t              sew_q, sew_d;
   logic [BIW-1:0]    last_idx_q, last_idx_d;
   logic [VLW-1:0]    vl_q, vl_d;
   tail_fill_t        tail_q, tail_d;
   logic [BIW-1:0]    beat_q, beat_d;
   logic              out_valid_q, out_valid_d;
   logic [VLEN-1:0]   vec_q, vec_d;
   logic [NB-1:0]     en_q, en_d;
   logic              last_q, last_d;

   logic              accept, advance;
   sew_t              in_sew;
   logic [1:0]        beats_log2;
   logic [31:0]       vlmax;
   logic [VLW-1:0]    in_vl;
   logic [BIW-1:0]    in_last_idx;
   logic [XLEN-1:0]   in_scalar;

   logic [XLEN-1:0]   f_scalar;
   sew_t              f_sew;
   logic [BIW-1:0]    f_beat;
   logic [VLW-1:0]    f_vl;
   tail_fill_t        f_tail;
   logic [VLEN-1:0]   f_vec;
   logic [NB-1:0]     f_en;

   // out_ready feeds in_ready directly so a new group can start on the last-beat edge
   assign in_ready = !reset && (state_q == IDLE || (state_q == EMIT && last_q && out_ready));
   assign accept   = in_valid && in_ready;
   assign advance  = (state_q == EMIT) && out_valid_q && out_ready;

   always_comb begin
      in_sew      = sew_t'(sew);
      beats_log2  = (lmul > MaxLog) ? MaxLog : lmul;
      vlmax       = (32'(NB) << beats_log2) >> in_sew;
      in_vl       = (32'(vl) < vlmax) ? vl : VLW'(vlmax);
      in_last_idx = BIW'((32'd1 << beats_log2) - 32'd1);
      in_scalar   = scalar_input;
      if (in_sew != SEW_64) begin
         in_scalar = scalar_input & ((XLEN'(1) << sew_bits(in_sew)) - XLEN'(1));
      end
   end

   always_comb begin
      f_scalar = accept ? in_scalar : scalar_q;
      f_sew    = accept ? in_sew : sew_q;
      f_beat   = accept ? '0 : beat_q + BIW'(1);
      f_vl     = accept ? in_vl : vl_q;
      f_tail   = accept ? tail_fill_t'(tail_fill) : tail_q;
   end

   broadcast_beat_former #(
      .VLEN (VLEN),
      .XLEN (XLEN),
      .BIW  (BIW),
      .VLW  (VLW)
   ) u_former (
      .scalar         (f_scalar),
      .sew            (f_sew),
      .beat           (f_beat),
      .vl             (f_vl),
      .tail_fill      (f_tail),
      .vector_output  (f_vec),
      .element_enable (f_en)
   );

   always_comb begin
      state_d     = state_q;
      scalar_d    = scalar_q;
      sew_d       = sew_q;
      last_idx_d  = last_idx_q;
      vl_d        = vl_q;
      tail_d      = tail_q;
      beat_d      = beat_q;
      out_valid_d = out_valid_q;
      vec_d       = vec_q;
      en_d        = en_q;
      last_d      = last_q;
      if (accept) begin
         scalar_d   = in_scalar;
         sew_d      = in_sew;
         last_idx_d = in_last_idx;
         vl_d       = in_vl;
         tail_d     = tail_fill_t'(tail_fill);
         if (in_vl == '0) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            last_d      = 1'b0;
         end else begin
            state_d     = EMIT;
            beat_d      = '0;
            out_valid_d = 1'b1;
            vec_d       = f_vec;
            en_d        = f_en;
            last_d      = (in_last_idx == '0);
         end
      end else if (advance) begin
         if (last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            last_d      = 1'b0;
         end else begin
            beat_d = f_beat;
            vec_d  = f_vec;
            en_d   = f_en;
            last_d = (f_beat == last_idx_q);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         scalar_q    <= '0;
         sew_q       <= SEW_8;
         last_idx_q  <= '0;
         vl_q        <= '0;
         tail_q      <= TAIL_ZERO;
         beat_q      <= '0;
         out_valid_q <= 1'b0;
         vec_q       <= '0;
         en_q        <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         scalar_q    <= scalar_d;
         sew_q       <= sew_d;
         last_idx_q  <= last_idx_d;
         vl_q        <= vl_d;
         tail_q      <= tail_d;
         beat_q      <= beat_d;
         out_valid_q <= out_valid_d;
         vec_q       <= vec_d;
         en_q        <= en_d;
         last_q      <= last_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign vector_output  = vec_q;
   assign element_enable = en_q;
   assign beat_index     = beat_q;
   assign last_beat      = last_q;

endmodule

// File: tb/tb_scalar_broadcast_sequencer.sv
// Directed and randomized checks of the broadcast sequencer against an element-level model.
module tb_scalar_broadcast_sequencer;

   localparam int VLEN     = 64;
   localparam int XLEN     = 64;
   localparam int MAX_LMUL = 8;
   localparam int VLW      = 7;
   localparam int BIW      = 3;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [63:0]     scalar_input = '0;
   logic [1:0]      sew = '0;
   logic [1:0]      lmul = '0;
   logic [VLW-1:0]  vl = '0;
   logic            tail_fill = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [63:0]     vector_output;
   logic [7:0]      element_enable;
   logic [BIW-1:0]  beat_index;
   logic            last_beat;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   scalar_broadcast_sequencer #(
      .VLEN     (VLEN),
      .XLEN     (XLEN),
      .MAX_LMUL (MAX_LMUL)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .scalar_input   (scalar_input),
      .sew            (sew),
      .lmul           (lmul),
      .vl             (vl),
      .tail_fill      (tail_fill),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .vector_output  (vector_output),
      .element_enable (element_enable),
      .beat_index     (beat_index),
      .last_beat      (last_beat)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int num_beats(logic [1:0] lm);
      int b;
      b = 1 << lm;
      if (b > MAX_LMUL) b = MAX_LMUL;
      return b;
   endfunction

   function automatic int eff_vl(logic [1:0] sw, logic [1:0] lm, int v);
      int vlmax;
      vlmax = num_beats(lm) * VLEN / (8 << sw);
      return (v < vlmax) ? v : vlmax;
   endfunction

   function automatic logic [63:0] exp_data(logic [63:0] s, logic [1:0] sw, int b, int vle,
                                            bit tf);
      int esz, epb, g;
      logic [63:0] r;
      esz = 8 << sw;
      epb = VLEN / esz;
      r   = '0;
      for (int i = 0; i < epb; i++) begin
         g = b * epb + i;
         for (int k = 0; k < esz; k++) r[i*esz+k] = (g < vle) ? s[k] : tf;
      end
      return r;
   endfunction

   function automatic logic [7:0] exp_en(logic [1:0] sw, int b, int vle);
      int bpe, epb;
      logic [7:0] r;
      bpe = 1 << sw;
      epb = 8 / bpe;
      for (int j = 0; j < 8; j++) r[j] = ((b * epb + j / bpe) < vle);
      return r;
   endfunction

   // mode 0: out_ready always high; 1: random; 2: low for the first three cycles
   task automatic run_group(input logic [63:0] s, input logic [1:0] sw, input logic [1:0] lm,
                            input int v, input bit tf, input int mode, input string nm);
      int beats, vle, b, cyc;
      bit rdy;
      beats = num_beats(lm);
      vle   = eff_vl(sw, lm, v);
      scalar_input = s;
      sew          = sw;
      lmul         = lm;
      vl           = VLW'(v);
      tail_fill    = tf;
      in_valid     = 1'b1;
      out_ready    = 1'b1;
      #1;
      chk({nm, "_in_ready_idle"}, in_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (vle == 0) begin
         repeat (3) begin
            chk({nm, "_drop_valid"}, out_valid, 0);
            chk({nm, "_drop_in_ready"}, in_ready, 1);
            @(posedge clock); #1;
         end
         return;
      end
      b   = 0;
      cyc = 0;
      while (b < beats) begin
         if (cyc > 100) begin
            chk({nm, "_timeout"}, b, beats);
            break;
         end
         chk({nm, "_valid"}, out_valid, 1);
         chk({nm, "_data"}, vector_output, exp_data(s, sw, b, vle, tf));
         chk({nm, "_en"}, element_enable, exp_en(sw, b, vle));
         chk({nm, "_idx"}, beat_index, b);
         chk({nm, "_last"}, last_beat, (b == beats - 1));
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (cyc >= 3);
         endcase
         out_ready = rdy;
         #1;
         chk({nm, "_in_ready"}, in_ready, (rdy && b == beats - 1));
         @(posedge clock); #1;
         if (rdy) b++;
         cyc++;
      end
      out_ready = 1'b1;
      chk({nm, "_valid_after"}, out_valid, 0);
      chk({nm, "_in_ready_after"}, in_ready, 1);
   endtask

   initial begin
      // reset behaviour
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", vector_output, 0);
      chk("rst_en", element_enable, 0);
      chk("rst_idx", beat_index, 0);
      chk("rst_last", last_beat, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      run_group(64'h123456789ABCDEA5, 2'b00, 2'b00, 8, 1'b0, 0, "sew8");
      run_group(64'hFFFF_0000_5555_1234, 2'b01, 2'b01, 5, 1'b0, 0, "sew16_t0");
      run_group(64'hFFFF_0000_5555_1234, 2'b01, 2'b01, 5, 1'b1, 0, "sew16_t1");
      run_group(64'hCAFE_F00D_DEAD_BEEF, 2'b10, 2'b11, 100, 1'b0, 0, "sew32_clamp");
      run_group(64'h0123_4567_89AB_CDEF, 2'b11, 2'b01, 9, 1'b1, 2, "backpressure");
      run_group(64'h0000_0000_0000_0077, 2'b00, 2'b10, 0, 1'b0, 0, "vl0");

      // back-to-back: next request held during the last-beat handshake
      scalar_input = 64'h0000_0000_0000_ABCD;
      sew = 2'b01; lmul = 2'b01; vl = 7'd8; tail_fill = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1;
      scalar_input = 64'h0000_0000_0000_003C;
      sew = 2'b00; lmul = 2'b00; vl = 7'd8;
      #1;
      chk("b2b_a0_data", vector_output, exp_data(64'hABCD, 2'b01, 0, 8, 1'b0));
      chk("b2b_a0_in_ready", in_ready, 0);
      @(posedge clock); #1;
      chk("b2b_a1_idx", beat_index, 1);
      chk("b2b_a1_last", last_beat, 1);
      chk("b2b_a1_in_ready", in_ready, 1);
      @(posedge clock); #1;
      chk("b2b_b0_valid", out_valid, 1);
      chk("b2b_b0_data", vector_output, exp_data(64'h3C, 2'b00, 0, 8, 1'b0));
      chk("b2b_b0_idx", beat_index, 0);
      chk("b2b_b0_last", last_beat, 1);
      vl = 7'd0;
      #1;
      chk("b2b_c_in_ready", in_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("b2b_c_drop_valid", out_valid, 0);
      chk("b2b_c_in_ready_idle", in_ready, 1);

      // reset in the middle of an 8-beat group
      scalar_input = 64'h0000_0000_1111_2222;
      sew = 2'b10; lmul = 2'b11; vl = 7'd16; tail_fill = 1'b0;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      chk("mid_idx3", beat_index, 3);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", vector_output, 0);
      chk("mid_rst_en", element_enable, 0);
      chk("mid_rst_idx", beat_index, 0);
      chk("mid_rst_last", last_beat, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      reset = 1'b0;
      #1;
      chk("mid_post_in_ready", in_ready, 1);
      repeat (3) begin
         @(posedge clock); #1;
         chk("mid_no_residual", out_valid, 0);
      end

      // randomized groups with random backpressure
      for (int n = 0; n < 40; n++) begin
         run_group({$urandom, $urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
